// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the synchronous fifo.
// Hides the fifo's one-cycle read latency behind a 2-entry buffer.
module fifo_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  words_read,
  output logic                  busy
);

  logic [1:0]            cnt;
  logic                  inflight;
  logic                  head;
  logic                  wptr;
  logic                  pop;
  logic [2:0]            used;
  logic [2:0]            room;
  logic                  has_credit;
  logic [DATA_WIDTH-1:0] mem [2];

  assign pop = m_valid & m_ready;

  // a slot freed by this cycle's pop may be refilled by a read issued now
  assign used       = {1'b0, cnt} + {2'b00, inflight};
  assign room       = 3'd2 + {2'b00, pop};
  assign has_credit = room > used;

  assign fifo_read_en = enable & ~fifo_empty & ~reset & has_credit;

  assign m_valid = (cnt != 2'd0);
  assign busy    = m_valid | inflight;
  assign m_data  = mem[head];
  assign wptr    = head ^ cnt[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= 2'd0;
      inflight   <= 1'b0;
      head       <= 1'b0;
      words_read <= '0;
      mem[0]     <= '0;
      mem[1]     <= '0;
    end else begin
      inflight <= fifo_read_en;
      if (inflight) begin
        mem[wptr] <= fifo_data;
      end
      if (pop) begin
        head       <= ~head;
        words_read <= words_read + CNT_WIDTH'(1);
      end
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: table vectors, directed corner sequences and a
// randomized run scored against an in-order queue model of the fifo.
module tb_fifo_reader;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_read_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] words_read;
  logic          busy;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] wq[$];
  logic [DW-1:0] exp_q[$];
  logic          fifo_clr = 1'b0;
  logic          rd_fire = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            model_cnt = 0;
  int            delivered = 0;
  int            pushed = 0;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_read_en(fifo_read_en),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .words_read(words_read),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // synchronous fifo model: registered data, one-cycle read latency
  always @(posedge clk) begin
    if (fifo_clr) fq.delete();
    else if (rd_fire && fq.size() != 0) fifo_data <= fq.pop_front();
    while (wq.size() != 0) fq.push_back(wq.pop_front());
    fifo_empty <= (fq.size() == 0);
  end

  // scoreboard: words leave the fifo in order and must reach m_data in order
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_cnt = 0;
      delivered = 0;
      prev_stall = 1'b0;
      rd_fire = 1'b0;
    end else begin
      if (fifo_empty) chk("rd_while_empty", fifo_read_en, 0);
      chk("busy", busy, exp_q.size() != 0);
      chk("words_read", words_read, model_cnt % (1 << CW));
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_underflow actual=%0h required=none", m_data);
        end else begin
          chk("order", m_data, exp_q.pop_front());
        end
        model_cnt++;
        delivered++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      rd_fire = fifo_read_en;
      if (fifo_read_en && fq.size() != 0) exp_q.push_back(fq[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fifo_clr = 1'b1;
    enable = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fifo_clr = 1'b0;
    reset = 1'b0;
  endtask

  task automatic preload(input int first, input int n);
    enable = 1'b0;
    for (int i = 0; i < n; i++) wq.push_back(DW'(first + i));
    tick();
    tick();
  endtask

  typedef struct {
    logic rst;
    logic en;
    logic empty;
    logic rdy;
    logic rd;
  } vec_t;

  vec_t tv[8];
  logic [DW-1:0] got[$];
  logic [CW-1:0] wr0;
  int rdn, vfirst, vlast, rcyc, vcyc;
  logic [DW-1:0] vdata;

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    m_ready = 1'b0;
    tv[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tv[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tv[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();

    // idle and reset-held read-issue table
    for (int i = 0; i < 8; i++) begin
      if (!tv[i].empty && fifo_empty) begin
        wq.push_back(32'h77);
        tick();
      end
      tick();
      reset = tv[i].rst;
      enable = tv[i].en;
      m_ready = tv[i].rdy;
      #1;
      chk($sformatf("tv%0d_empty", i), fifo_empty, tv[i].empty);
      chk($sformatf("tv%0d_rd", i), fifo_read_en, tv[i].rd);
      chk($sformatf("tv%0d_valid", i), m_valid, 0);
      chk($sformatf("tv%0d_busy", i), busy, 0);
      chk($sformatf("tv%0d_words", i), words_read, 0);
      chk($sformatf("tv%0d_data", i), m_data, 0);
      #1;
      reset = 1'b0;
      enable = 1'b0;
      m_ready = 1'b0;
    end
    do_reset();

    // single word: read strobe once, m_valid two cycles later
    enable = 1'b1;
    m_ready = 1'b1;
    wq.push_back(32'd50);
    rdn = 0; rcyc = -1; vcyc = -1; vdata = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (fifo_read_en) begin
        rdn++;
        if (rcyc < 0) rcyc = c;
      end
      if (m_valid && vcyc < 0) begin
        vcyc = c;
        vdata = m_data;
      end
    end
    chk("single_rd_pulses", rdn, 1);
    chk("single_latency", vcyc - rcyc, 2);
    chk("single_data", vdata, 50);
    chk("single_words", words_read, 1);
    chk("single_busy", busy, 0);

    // stream of 8 with continuous ready: no gaps
    preload(1, 8);
    wr0 = words_read;
    enable = 1'b1;
    m_ready = 1'b1;
    got.delete(); vfirst = -1; vlast = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_valid) begin
        got.push_back(m_data);
        if (vfirst < 0) vfirst = c;
        vlast = c;
      end
    end
    chk("stream_count", got.size(), 8);
    chk("stream_gapless", vlast - vfirst, 7);
    for (int k = 0; k < got.size(); k++) chk("stream_data", got[k], k + 1);
    chk("stream_words", CW'(words_read - wr0), 8);

    // backpressure: two reads fill the buffer, head word held
    preload(1, 8);
    enable = 1'b1;
    m_ready = 1'b0;
    rdn = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (fifo_read_en) rdn++;
    end
    chk("bp_rd_pulses", rdn, 2);
    chk("bp_valid", m_valid, 1);
    chk("bp_head", m_data, 1);
    tick();
    m_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (m_valid) got.push_back(m_data);
    end
    chk("bp_count", got.size(), 8);
    for (int k = 0; k < got.size(); k++) chk("bp_order", got[k], k + 1);

    // enable drop with a read in flight, then drain to empty
    preload(10, 5);
    m_ready = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    chk("en_first_rd", fifo_read_en, 1);
    tick();
    enable = 1'b0;
    rdn = 0;
    got.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (fifo_read_en) rdn++;
      if (m_valid) got.push_back(m_data);
    end
    chk("en_no_more_rd", rdn, 0);
    chk("en_inflight_cnt", got.size(), 1);
    if (got.size() != 0) chk("en_inflight_data", got[0], 10);
    tick();
    enable = 1'b1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_valid) got.push_back(m_data);
    end
    chk("drain_count", got.size(), 4);
    for (int k = 0; k < got.size(); k++) chk("drain_data", got[k], k + 11);
    chk("drain_empty", fifo_empty, 1);
    chk("drain_busy", busy, 0);

    // reset mid-stream with the buffer full
    do_reset();
    enable = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) wq.push_back(DW'(100 + i));
    for (int c = 0; c < 10 && !m_valid; c++) @(negedge clk);
    tick();
    chk("mid_valid", m_valid, 1);
    chk("mid_busy", busy, 1);
    #2;
    reset = 1'b1;
    fifo_clr = 1'b1;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_words", words_read, 0);
    chk("mid_rst_rd", fifo_read_en, 0);
    chk("mid_rst_data", m_data, 0);
    repeat (2) @(posedge clk);
    #1;
    fifo_clr = 1'b0;
    reset = 1'b0;
    m_ready = 1'b1;
    wq.push_back(32'hA5);
    for (int c = 0; c < 10 && !m_valid; c++) @(negedge clk);
    chk("refill_valid", m_valid, 1);
    chk("refill_data", m_data, 32'hA5);
    tick();
    tick();

    // randomized traffic against the queue model
    do_reset();
    pushed = 0;
    for (int c = 0; c < 1500; c++) begin
      enable = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0) begin
        wq.push_back($urandom);
        pushed++;
      end
      tick();
    end
    enable = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (fq.size() == 0 && wq.size() == 0 && !busy) break;
    end
    chk("rand_drained", busy, 0);
    chk("rand_delivered", delivered, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
